instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the 8-bit RISC pipeline and the producer side of the opcode interface. It owns the PC and fetches 16-bit instructions from a variable-latency instruction memory using a req/valid handshake.
- It loads the IF/ID register, whose opcode field drives the control decoder.
- It honours stall from the hazard unit and redirect/flush from the EX-stage branch resolution.

Parameters:
- ADDR_W, 8, PC / instruction-memory address width.
- INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1:INSTR_W-4].
- RESET_PC, 0, PC value after reset.
- NOP_INSTR, 16'hF000, bubble instruction (opcode 4'hF).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  one-cycle request strobe.
- imem_addr  out  ADDR_W  address, valid while imem_req=1.
- imem_valid  in  1  response strobe; at most one response per request, ≥1 cycle after req.
- imem_rdata  in  INSTR_W  instruction, valid with imem_valid.
- stall  in  1  hazard unit: hold IF/ID contents.
- branch_taken  in  1  EX redirect request.
- branch_target  in  ADDR_W  redirect address.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  INSTR_W  IF/ID instruction.
- ifid_pc  out  ADDR_W  PC of ifid_instr.
- ifid_opcode  out  4  ifid_instr[INSTR_W-1:INSTR_W-4], to the control decoder.

Behaviour:
Reset (rst=1 at a clk edge):
- pc=RESET_PC, state=S_REQ, drop=0, imem_req=0.
- ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_opcode=4'hF.

FSM (S_REQ, S_WAIT, S_HOLD); all outputs registered:
- S_REQ: imem_req=1, imem_addr=pc for exactly one cycle, then go to S_WAIT.
- S_WAIT, imem_valid=1 with drop=0:
  - stall=0: IF/ID <= {1, imem_rdata, pc}; pc <= pc+1; go to S_REQ.
  - stall=1: capture imem_rdata into pend_instr; go to S_HOLD.
- S_WAIT, imem_valid=1 with drop=1: discard the data, clear drop, go to S_REQ.
- S_HOLD: IF/ID held while stall=1. On stall=0: IF/ID <= {1, pend_instr, pc}; pc <= pc+1; go to S_REQ.

Stall:
- IF/ID outputs are unchanged in every cycle where stall=1 and branch_taken=0.

Redirect (branch_taken=1) has priority over stall and imem_valid in every state:
- pc <= branch_target.
- IF/ID <= {0, NOP_INSTR, 0}, i.e. flushed.
- pend_instr is discarded.
- From S_WAIT with imem_valid=0: drop <= 1, stay in S_WAIT (outstanding response is wrong-path).
- From S_WAIT with imem_valid=1 in the same cycle: discard the data, drop stays 0, go to S_REQ.
- From S_REQ: the request issued this cycle is wrong-path; drop <= 1, go to S_WAIT.
- From S_HOLD: go to S_REQ.

Other rules:
- Width: pc+1 is modulo 2^ADDR_W; (2^ADDR_W)-1 wraps to 0.
- Only one request is outstanding at a time. Throughput is one instruction per 2 cycles with 1-cycle memory latency.
- rst mid-transaction: any late imem_valid arriving in S_REQ after reset is ignored.
- ifid_opcode is always the top 4 bits of ifid_instr. A flushed slot presents 4'hF, which decodes as NOP with all control outputs 0.

Decomposition:
- Shared package risc8_pkg: OPC_NOP=4'hF, NOP_INSTR, INSTR_W, ADDR_W, fetch state enum {S_REQ, S_WAIT, S_HOLD}.
- One sub-module, ifid_reg: IF/ID pipeline register with hold (stall) and flush (load NOP, valid=0) controls. The FSM, PC and drop logic stay in instr_fetch_unit.

Test Plan:
1. Reset, then memory with 1-cycle latency returning 16'h0123 @0, 16'h1456 @1 -> imem_addr 0,1,2 on successive req pulses; ifid_instr 0123 (opcode 0, pc 0) then 1456 (opcode 1, pc 1); ifid_valid=1.
2. Stall held 3 cycles when 16'h4789 @5 returns -> IF/ID holds the previous instruction; S_HOLD entered. Release stall -> ifid_instr=4789, ifid_pc=5, next req addr=6.
3. branch_taken with target 8'h40 while S_WAIT and response pending (3-cycle latency) -> ifid_valid=0, opcode F; stale response discarded; next imem_addr=40; ifid_pc=40 after its response.
4. branch_taken in the same cycle as imem_valid, with stall=1 -> branch wins; data discarded; no drop; req to target on the next cycle.
5. pc=8'hFF fetch -> ifid_pc=FF, next imem_addr=00.
6. rst asserted in S_WAIT, late imem_valid arrives 1 cycle later -> ignored; first req after reset at RESET_PC; ifid_valid stays 0 until the new response.

Source files
------------

// File: rtl/risc8_pkg.sv
// Shared constants and types for the 8-bit RISC front end.
package risc8_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned INSTR_W   = 16;
    localparam logic [3:0]  OPC_NOP   = 4'hF;
    localparam logic [15:0] NOP_INSTR = {OPC_NOP, 12'h000};

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush loads a NOP bubble, hold freezes the contents.
module ifid_reg #(
    parameter int unsigned        ADDR_W    = risc8_pkg::ADDR_W,
    parameter int unsigned        INSTR_W   = risc8_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_INSTR = risc8_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hold,
    input  logic               flush,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc,
    output logic [3:0]         opcode
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            pc_d    = '0;
        end else if (load && !hold) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc_d    = load_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid  = valid_q;
    assign instr  = instr_q;
    assign pc     = pc_q;
    assign opcode = instr_q[INSTR_W-1 -: 4];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs the single-outstanding imem req/valid handshake
// and feeds the IF/ID register, honouring stall and EX-stage redirects.
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W    = risc8_pkg::ADDR_W,
    parameter int unsigned        INSTR_W   = risc8_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = risc8_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [3:0]         ifid_opcode
);

    import risc8_pkg::*;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               drop_q, drop_d;
    logic [INSTR_W-1:0] pend_instr_q, pend_instr_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               ifid_flush;
    logic               ifid_load;
    logic [INSTR_W-1:0] ifid_load_instr;

    // imem_req is registered from the next state, so the strobe is visible during
    // the S_REQ cycle itself; the first S_REQ cycle after reset only arms it.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        drop_d          = drop_q;
        pend_instr_d    = pend_instr_q;
        ifid_flush      = 1'b0;
        ifid_load       = 1'b0;
        ifid_load_instr = imem_rdata;

        if (branch_taken) begin
            pc_d       = branch_target;
            ifid_flush = 1'b1;
            case (state_q)
                S_REQ: begin
                    if (req_q) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_q) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (stall) begin
                            pend_instr_d = imem_rdata;
                            state_d      = S_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                            pc_d      = pc_q + ADDR_W'(1);
                            state_d   = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_load       = 1'b1;
                        ifid_load_instr = pend_instr_q;
                        pc_d            = pc_q + ADDR_W'(1);
                        state_d         = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end

        req_d  = (state_d == S_REQ);
        addr_d = req_d ? pc_d : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_q       <= 1'b0;
            pend_instr_q <= NOP_INSTR;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_q       <= drop_d;
            pend_instr_q <= pend_instr_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

    ifid_reg #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .hold      (stall),
        .flush     (ifid_flush),
        .load      (ifid_load),
        .load_instr(ifid_load_instr),
        .load_pc   (pc_q),
        .valid     (ifid_valid),
        .instr     (ifid_instr),
        .pc        (ifid_pc),
        .opcode    (ifid_opcode)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit: epoch-tagged fetch model plus IF/ID scoreboard.
module tb_instr_fetch_unit;
    import risc8_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic [3:0]  ifid_opcode;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00),
        .NOP_INSTR(16'hF000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .ifid_valid   (ifid_valid),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_opcode  (ifid_opcode)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] i;
        logic [7:0]  p;
    } ifid_t;

    typedef struct packed {
        int unsigned due;
        logic [7:0]  a;
        logic [15:0] d;
        int unsigned ep;
    } resp_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    ifid_t       exp_q[$];
    ifid_t       m_last;
    bit          m_have_last = 1'b0;
    resp_t       resp_q[$];
    logic [15:0] mem [256];

    // Fetch model: every redirect or reset opens a new epoch; responses to
    // requests from an older epoch are wrong-path and vanish.
    int unsigned cyc = 0;
    int unsigned epoch = 0;
    int unsigned lat = 1;
    logic [7:0]  fetch_pc = 8'h00;
    bit          held = 1'b0;
    logic [15:0] held_i;
    logic [7:0]  held_p;
    bit          prev_rst = 1'b1;
    bit          req_seen = 1'b0;

    int unsigned stall_left = 0;
    int          stall_trig = -1;
    bit          br_on_fire = 1'b0;
    logic [7:0]  br_on_fire_tgt = 8'h00;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic void model_set(ifid_t t);
        if (!m_have_last || t != m_last) begin
            exp_q.push_back(t);
            m_last      = t;
            m_have_last = 1'b1;
        end
    endfunction

    task automatic step(input bit r, input bit st, input bit br, input logic [7:0] tgt);
        resp_t f;
        resp_t nf;
        bit    fire;
        bit    st_e;
        bit    br_e;
        bit    outstanding;
        logic [7:0] tgt_e;
        ifid_t t;

        @(negedge clk);
        cyc++;
        if (prev_rst) check("req_low_after_reset", 32'(imem_req), 32'(0));

        req_seen = 1'b0;
        if (imem_req === 1'b1) begin
            outstanding = held;
            foreach (resp_q[k]) if (resp_q[k].ep == epoch) outstanding = 1'b1;
            check("one_outstanding", 32'(outstanding), 32'(0));
            check("imem_addr", 32'(imem_addr), 32'(fetch_pc));
            nf.due = cyc + lat;
            nf.a   = imem_addr;
            nf.d   = mem[imem_addr];
            nf.ep  = epoch;
            resp_q.push_back(nf);
            req_seen = 1'b1;
        end

        fire = 1'b0;
        f    = '0;
        if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
            f    = resp_q.pop_front();
            fire = 1'b1;
        end

        st_e  = st;
        br_e  = br;
        tgt_e = tgt;
        if (fire && f.ep == epoch && stall_trig >= 0 && f.a == 8'(stall_trig)) begin
            stall_left = 3;
            stall_trig = -1;
        end
        if (stall_left > 0) begin
            st_e = 1'b1;
            stall_left--;
        end
        if (fire && br_on_fire) begin
            br_e       = 1'b1;
            tgt_e      = br_on_fire_tgt;
            st_e       = 1'b1;
            br_on_fire = 1'b0;
        end

        rst           = r;
        stall         = st_e;
        branch_taken  = br_e;
        branch_target = tgt_e;
        imem_valid    = fire;
        imem_rdata    = fire ? f.d : 16'($urandom);

        if (r || br_e) begin
            epoch++;
            held     = 1'b0;
            fetch_pc = r ? 8'h00 : tgt_e;
            t        = {1'b0, NOP_INSTR, 8'h00};
            model_set(t);
        end else begin
            if (fire && f.ep == epoch) begin
                held   = 1'b1;
                held_i = f.d;
                held_p = f.a;
            end
            if (held && !st_e) begin
                t        = {1'b1, held_i, held_p};
                model_set(t);
                fetch_pc = held_p + 8'd1;
                held     = 1'b0;
            end
        end
        prev_rst = r;
    endtask

    task automatic wait_req(input string name);
        int unsigned n;
        n = 0;
        while (!req_seen && n < 20) begin
            step(0, 0, 0, 8'h00);
            n++;
        end
        if (!req_seen) check(name, 32'(0), 32'(1));
    endtask

    // Monitor: every visible change of the IF/ID register consumes one expectation.
    initial begin
        ifid_t cur;
        ifid_t prev;
        ifid_t e;
        bit    have;
        have = 1'b0;
        prev = '0;
        forever begin
            @(posedge clk);
            #2;
            cur = {ifid_valid, ifid_instr, ifid_pc};
            if (!have || cur !== prev) begin
                have = 1'b1;
                prev = cur;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL ifid_unexpected_change: got v=%0b instr=%0h pc=%0h, expected no change (t=%0t)",
                             ifid_valid, ifid_instr, ifid_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("ifid_valid",  32'(ifid_valid),  32'(e.v));
                    check("ifid_instr",  32'(ifid_instr),  32'(e.i));
                    check("ifid_pc",     32'(ifid_pc),     32'(e.p));
                    check("ifid_opcode", 32'(ifid_opcode), 32'(e.i[15:12]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        ifid_t t0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h0123;
        mem[1] = 16'h1456;
        mem[5] = 16'h4789;

        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 8'h00;
        imem_valid    = 1'b0;
        imem_rdata    = 16'h0000;
        t0 = {1'b0, NOP_INSTR, 8'h00};
        model_set(t0);

        step(1, 0, 0, 8'h00);
        step(1, 0, 0, 8'h00);

        // Sequential fetch with 1-cycle memory, then a 3-cycle stall when @5 returns.
        lat        = 1;
        stall_trig = 5;
        repeat (24) step(0, 0, 0, 8'h00);
        check("stall_trigger_hit", 32'(stall_trig), 32'(-1));

        // Redirect to 0x40 while a 3-cycle response is outstanding.
        lat = 3;
        wait_req("wait_req_timeout_redirect");
        step(0, 0, 1, 8'h40);
        repeat (16) step(0, 0, 0, 8'h00);

        // Redirect coinciding with imem_valid, under stall.
        lat            = 2;
        br_on_fire     = 1'b1;
        br_on_fire_tgt = 8'h80;
        repeat (12) step(0, 0, 0, 8'h00);
        check("branch_on_valid_hit", 32'(br_on_fire), 32'(0));

        // PC wrap from 0xFF to 0x00.
        lat = 1;
        wait_req("wait_req_timeout_wrap");
        step(0, 0, 1, 8'hFF);
        repeat (12) step(0, 0, 0, 8'h00);

        // Reset while waiting; the late response lands in the cycle after reset.
        lat = 2;
        wait_req("wait_req_timeout_reset");
        step(1, 0, 0, 8'h00);
        lat = 1;
        repeat (12) step(0, 0, 0, 8'h00);

        // Random traffic.
        repeat (800) begin
            lat = $urandom_range(4, 1);
            step(0, ($urandom % 4) == 0, ($urandom % 20) == 0, 8'($urandom));
        end
        repeat (12) step(0, 0, 0, 8'h00);

        @(posedge clk);
        #3;
        check("ifid_expected_left", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
